axi_lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank. It is the next-generation control/status interface for the DCC central IP and replaces the fixed 4-register slave. It adds a configurable register count, byte-strobe writes, read-only status registers fed from the fabric, per-register write strobes, and independent AW/W acceptance. It sits between the PS/VIP AXI master and the DCC datapath.

---
 rtl/axi_lite_regbank.sv | 210 +++++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: RW control registers, RO status registers, per-register write pulses.
// Optional build macro REGBANK_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned NUM_RO     = 2,
  parameter logic [31:0] RESET_VAL  = 32'h0
) (
  input  logic                                      ACLK,
  input  logic                                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]                     S_AXI_AWADDR,
  input  logic [2:0]                                S_AXI_AWPROT,
  input  logic                                      S_AXI_AWVALID,
  output logic                                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]                     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                   S_AXI_WSTRB,
  input  logic                                      S_AXI_WVALID,
  output logic                                      S_AXI_WREADY,
  output logic [1:0]                                S_AXI_BRESP,
  output logic                                      S_AXI_BVALID,
  input  logic                                      S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]                     S_AXI_ARADDR,
  input  logic [2:0]                                S_AXI_ARPROT,
  input  logic                                      S_AXI_ARVALID,
  output logic                                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]                     S_AXI_RDATA,
  output logic [1:0]                                S_AXI_RRESP,
  output logic                                      S_AXI_RVALID,
  input  logic                                      S_AXI_RREADY,
  output logic [(NUM_REGS-NUM_RO)*32-1:0]           reg_out,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] status_in,
  output logic [NUM_REGS-NUM_RO-1:0]                wr_pulse
);

  localparam int unsigned NUM_RW = NUM_REGS - NUM_RO;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef REGBANK_SLVERR_EN
  localparam logic [1:0]  RESP_OOR  = 2'b10;
`else
  localparam logic [1:0]  RESP_OOR  = 2'b00;
`endif

  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("axi_lite_regbank: DATA_WIDTH must be 32");
  end
  if ((2 ** (ADDR_WIDTH - 2)) < NUM_REGS) begin : g_aw_chk
    $error("axi_lite_regbank: ADDR_WIDTH too small for NUM_REGS");
  end
  if (NUM_RO >= NUM_REGS) begin : g_ro_chk
    $error("axi_lite_regbank: NUM_RO must be below NUM_REGS");
  end

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;

  w_state_e                  w_state_q, w_state_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [IDX_W-1:0]          awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic [NUM_RW-1:0]         wr_pulse_q, wr_pulse_d;
  logic                      aw_hs_c, w_hs_c, commit_c;
  logic [DATA_WIDTH-1:0]     regs_q [NUM_RW];

  logic                      rst_done_q;
  logic                      rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      arready_c, ar_hs_c;
  logic [IDX_W-1:0]          aridx_c;
  logic [DATA_WIDTH-1:0]     rsel_c;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM next state; the _d copies of address/data already include same-cycle bypass.
  always_comb begin
    w_state_d = w_state_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit_c  = 1'b0;
    aw_hs_c   = S_AXI_AWVALID && awready_q;
    w_hs_c    = S_AXI_WVALID && wready_q;
    if (aw_hs_c) awidx_d = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    if (w_hs_c) begin
      wdata_d = S_AXI_WDATA;
      wstrb_d = S_AXI_WSTRB;
    end
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) commit_c = 1'b1;
        else if (aw_hs_c)      w_state_d = W_HAVE_AW;
        else if (w_hs_c)       w_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs_c) commit_c = 1'b1;
      W_HAVE_W:  if (aw_hs_c) commit_c = 1'b1;
      W_RESP:    if (S_AXI_BREADY) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase
    if (commit_c) begin
      w_state_d = W_RESP;
      bresp_d   = (32'(awidx_d) >= NUM_REGS) ? RESP_OOR : RESP_OKAY;
    end
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
    bvalid_d  = (w_state_d == W_RESP);
    for (int i = 0; i < NUM_RW; i++) begin
      wr_pulse_d[i] = commit_c && (awidx_d == IDX_W'(i));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Byte-lane merge into the addressed RW register; RO and out-of-range indices match no entry.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= RESET_VAL;
    end else if (commit_c) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (awidx_d == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_d[b]) regs_q[i][8*b +: 8] <= wdata_d[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: ARREADY opens when the response slot is empty or draining this cycle.
  always_comb begin
    arready_c = rst_done_q && (!rvalid_q || S_AXI_RREADY);
    ar_hs_c   = S_AXI_ARVALID && arready_c;
    aridx_c   = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    rsel_c    = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (aridx_c == IDX_W'(i)) rsel_c = regs_q[i];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (aridx_c == IDX_W'(NUM_RW + j)) rsel_c = status_in[32*j +: 32];
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rdata_d  = rsel_c;
      rresp_d  = (32'(aridx_c) >= NUM_REGS) ? RESP_OOR : RESP_OKAY;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rst_done_q <= 1'b1;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_c;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: vector table, corner-case sequences, random traffic vs a model.
module tb_axi_lite_regbank;

  localparam int unsigned AW       = 6;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned NUM_RO   = 2;
  localparam int unsigned NUM_RW   = NUM_REGS - NUM_RO;
  localparam logic [31:0] RST_VAL  = 32'h0;
`ifdef REGBANK_SLVERR_EN
  localparam logic [1:0]  OOR = 2'b10;
`else
  localparam logic [1:0]  OOR = 2'b00;
`endif

  logic                     ACLK = 1'b0;
  logic                     ARESETN;
  logic [AW-1:0]            S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]               S_AXI_AWPROT, S_AXI_ARPROT;
  logic                     S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]              S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]               S_AXI_WSTRB;
  logic [1:0]               S_AXI_BRESP, S_AXI_RRESP;
  logic                     S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic                     S_AXI_RVALID, S_AXI_RREADY;
  logic [NUM_RW*32-1:0]     reg_out;
  logic [NUM_RO*32-1:0]     status_vec;
  logic [NUM_RW-1:0]        wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt [NUM_RW] = '{default: 0};
  logic [31:0] model_rw [NUM_RW];

  always #5 ACLK = ~ACLK;

  axi_lite_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NUM_REGS),
                     .NUM_RO(NUM_RO), .RESET_VAL(RST_VAL)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .reg_out(reg_out), .status_in(status_vec), .wr_pulse(wr_pulse)
  );

  // Count high cycles of every write pulse.
  always @(negedge ACLK) begin
    for (int i = 0; i < NUM_RW; i++) if (wr_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < NUM_RW; i++) s += pulse_cnt[i];
    return s;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
    return (int'(a >> 2) >= NUM_REGS) ? OOR : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx < NUM_RW) return model_rw[idx];
    if (idx < NUM_REGS) return status_vec[32*(idx-NUM_RW) +: 32];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (idx < NUM_RW) model_rw[idx] = merge(model_rw[idx], d, s);
  endtask

  task automatic chk_regs(input string name);
    for (int i = 0; i < NUM_RW; i++) chk(name, 64'(reg_out[32*i +: 32]), 64'(model_rw[i]));
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdelay, input logic [1:0] eresp);
    int idx, n, aw_lead, w_lead, tot_before;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [NUM_RW-1:0] ep;
    idx = int'(a >> 2);
    ep = '0;
    if (idx < NUM_RW) ep[idx] = 1'b1;
    tot_before = pulse_total();
    aw_lead = (lead > 0) ? lead : 0;
    w_lead  = (lead < 0) ? -lead : 0;
    @(posedge ACLK); #1;
    n = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && n < 50) begin
      if (!aw_done && n >= aw_lead) begin S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1; end
      if (!w_done && n >= w_lead) begin S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1; end
      @(negedge ACLK);
      if (w_done && !aw_done) chk("have_w_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(2'b10));
      if (aw_done && !w_done) chk("have_aw_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(2'b01));
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      n++;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs) begin S_AXI_WVALID = 1'b0; w_done = 1; end
    end
    if (!(aw_done && w_done)) begin
      chk("write_handshake_timeout", 64'(0), 64'(1));
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      return;
    end
    @(negedge ACLK);
    chk("bvalid_latency", 64'(S_AXI_BVALID), 64'(1));
    chk("wr_pulse", 64'(wr_pulse), 64'(ep));
    chk("bresp", 64'(S_AXI_BRESP), 64'(eresp));
    chk("resp_readies_low", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(0));
    for (int c = 0; c < bdelay; c++) begin
      @(negedge ACLK);
      chk("bvalid_hold", 64'(S_AXI_BVALID), 64'(1));
      chk("pulse_one_cycle", 64'(wr_pulse), 64'(0));
      chk("hold_readies_low", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(0));
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    chk("bvalid_clear", 64'(S_AXI_BVALID), 64'(0));
    chk("idle_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(2'b11));
    chk("pulse_count", 64'(pulse_total() - tot_before), 64'((idx < NUM_RW) ? 1 : 0));
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int rdelay,
                          output logic [31:0] d, output logic [1:0] r);
    int n;
    bit done, hs;
    d = '0; r = '0;
    @(posedge ACLK); #1;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0; done = 0;
    while (!done && n < 50) begin
      @(negedge ACLK);
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      n++;
      if (hs) begin S_AXI_ARVALID = 1'b0; done = 1; end
    end
    if (!done) begin
      chk("read_handshake_timeout", 64'(0), 64'(1));
      S_AXI_ARVALID = 1'b0;
      return;
    end
    @(negedge ACLK);
    chk("rvalid_latency", 64'(S_AXI_RVALID), 64'(1));
    d = S_AXI_RDATA; r = S_AXI_RRESP;
    for (int c = 0; c < rdelay; c++) begin
      @(negedge ACLK);
      chk("rvalid_hold", 64'(S_AXI_RVALID), 64'(1));
      chk("rdata_stable", 64'({S_AXI_RDATA, S_AXI_RRESP}), 64'({d, r}));
      chk("arready_blocked", 64'(S_AXI_ARREADY), 64'(0));
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    chk("rvalid_clear", 64'(S_AXI_RVALID), 64'(0));
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    logic [31:0]   exp_data;
    logic [1:0]    exp_resp;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  initial begin
    logic [31:0] rd, old;
    logic [1:0]  rr;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    vec[0]  = '{1'b1, 6'h00, 32'h1,        4'hF, 32'h0,        2'b00};
    vec[1]  = '{1'b1, 6'h04, 32'h2,        4'hF, 32'h0,        2'b00};
    vec[2]  = '{1'b1, 6'h08, 32'h3,        4'hF, 32'h0,        2'b00};
    vec[3]  = '{1'b1, 6'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
    vec[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h1,        2'b00};
    vec[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'h2,        2'b00};
    vec[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 32'h3,        2'b00};
    vec[7]  = '{1'b0, 6'h0D, 32'h0,        4'h0, 32'h4,        2'b00};
    vec[8]  = '{1'b1, 6'h00, 32'hAABBCCDD, 4'hF, 32'h0,        2'b00};
    vec[9]  = '{1'b1, 6'h00, 32'h11223344, 4'h5, 32'h0,        2'b00};
    vec[10] = '{1'b0, 6'h00, 32'h0,        4'h0, 32'hAA22CC44, 2'b00};
    vec[11] = '{1'b1, 6'h18, 32'h0,        4'hF, 32'h0,        2'b00};
    vec[12] = '{1'b0, 6'h18, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vec[13] = '{1'b0, 6'h1C, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
    vec[14] = '{1'b1, 6'h3C, 32'h12345678, 4'hF, 32'h0,        OOR};
    vec[15] = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0,        OOR};
    vec[16] = '{1'b1, 6'h10, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00};
    vec[17] = '{1'b0, 6'h10, 32'h0,        4'h0, 32'h0,        2'b00};
    vec[18] = '{1'b1, 6'h14, 32'h5A5A5A5A, 4'h3, 32'h0,        2'b00};
    vec[19] = '{1'b0, 6'h14, 32'h0,        4'h0, 32'h00005A5A, 2'b00};

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    status_vec = {32'hCAFEF00D, 32'hDEADBEEF};
    for (int i = 0; i < NUM_RW; i++) model_rw[i] = RST_VAL;

    // Reset values, then readies rise on the first edge after release.
    @(negedge ACLK);
    chk("rst_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(0));
    chk("rst_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(0));
    chk("rst_pulse", 64'(wr_pulse), 64'(0));
    chk_regs("rst_reg_out");
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("release_readies_low", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(0));
    @(negedge ACLK);
    chk("release_readies_high", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(3'b111));

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      if (vec[i].wr) begin
        axi_write(vec[i].addr, vec[i].data, vec[i].strb, 0, 0, vec[i].exp_resp);
        model_write(vec[i].addr, vec[i].data, vec[i].strb);
      end else begin
        axi_read(vec[i].addr, 0, rd, rr);
        chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vec[i].exp_data));
        chk($sformatf("vec%0d_rresp", i), 64'(rr), 64'(vec[i].exp_resp));
      end
    end
    chk_regs("table_reg_out");

    // W three cycles ahead of AW, BREADY held off for five cycles.
    axi_write(6'h08, 32'h0BADF00D, 4'hF, 3, 5, 2'b00);
    model_write(6'h08, 32'h0BADF00D, 4'hF);
    chk("w_first_reg2", 64'(reg_out[64 +: 32]), 64'(32'h0BADF00D));
    axi_read(6'h08, 3, rd, rr);
    chk("w_first_readback", 64'(rd), 64'(32'h0BADF00D));

    // Read and write of the same register committing on the same edge returns the old value.
    old = model_rw[2];
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1; S_AXI_WDATA = 32'h600DCAFE; S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1; S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    chk("same_cycle_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(3'b111));
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model_write(6'h08, 32'h600DCAFE, 4'hF);
    @(negedge ACLK);
    chk("same_cycle_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(2'b11));
    chk("same_cycle_old_value", 64'(S_AXI_RDATA), 64'(old));
    chk("same_cycle_new_reg", 64'(reg_out[64 +: 32]), 64'(32'h600DCAFE));
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;

    // Back-to-back reads with RREADY held high.
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b1; S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    chk("b2b_arready0", 64'(S_AXI_ARREADY), 64'(1));
    @(posedge ACLK); #1;
    S_AXI_ARADDR = 6'h04;
    @(negedge ACLK);
    chk("b2b_rdata0", 64'({S_AXI_RVALID, S_AXI_RDATA}), 64'({1'b1, model_rw[0]}));
    chk("b2b_arready1", 64'(S_AXI_ARREADY), 64'(1));
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("b2b_rdata1", 64'({S_AXI_RVALID, S_AXI_RDATA}), 64'({1'b1, model_rw[1]}));
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    chk("b2b_rvalid_clear", 64'(S_AXI_RVALID), 64'(0));

    // Random traffic against the model.
    for (int k = 0; k < 80; k++) begin
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)), exp_resp(a));
        model_write(a, d, s);
        chk_regs("rand_reg_out");
      end else begin
        for (int j = 0; j < NUM_RO; j++) status_vec[32*j +: 32] = $urandom;
        axi_read(a, int'($urandom_range(0, 2)), rd, rr);
        chk("rand_rdata", 64'(rd), 64'(model_read(a)));
        chk("rand_rresp", 64'(rr), 64'(exp_resp(a)));
      end
    end

    // Reset while both responses are pending.
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1; S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("pre_reset_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(2'b11));
    #2 ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NUM_RW; i++) model_rw[i] = RST_VAL;
    chk("async_rst_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(0));
    chk("async_rst_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(0));
    chk("async_rst_resp_data", 64'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 64'(0));
    chk("async_rst_pulse", 64'(wr_pulse), 64'(0));
    chk_regs("async_rst_reg_out");
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rerelease_readies_low", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(0));
    @(negedge ACLK);
    chk("rerelease_readies_high", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(3'b111));
    axi_read(6'h00, 0, rd, rr);
    chk("post_reset_read0", 64'({rd, rr}), 64'({RST_VAL, 2'b00}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
